// File: rtl/axis_burst_reader_pkg.sv
// axis_burst_pkg: burst-length clamp and close-reason encoding shared by the burst reader
package axis_burst_pkg;
  typedef enum logic [1:0] {CLOSE_NONE, CLOSE_LEN, CLOSE_TMO, CLOSE_FLUSH} close_e;
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len == 0) ? 1 : (len > max_len) ? max_len : len;
  endfunction
endpackage

// File: rtl/axis_burst_reader_if.sv
// axis_burst_reader_if: AXI-stream channel (tdata/tvalid/tready/tlast)
//   master: drives tdata/tvalid/tlast, receives tready
//   slave : receives tdata/tvalid/tlast, drives tready
interface axis_burst_reader_if #(parameter int WIDTH = 12);
  logic [WIDTH-1:0] tdata;
  logic tvalid, tready, tlast;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_burst_reader_timer.sv
// axis_burst_timer: saturating idle timer with timeout compare
//   clk/rstn    clock, async active-low reset
//   clr         clears the timer (accept or move)
//   inc         counts one idle cycle
//   cfg_timeout idle cycles before tmo_hit; 0 disables
//   tmo_hit     timer has reached cfg_timeout
module axis_burst_timer #(parameter int TIMEOUT_BITS = 8) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    inc,
  input  logic [TIMEOUT_BITS-1:0] cfg_timeout,
  output logic                    tmo_hit
);
  logic [TIMEOUT_BITS-1:0] r_timer;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_timer <= '0;
    else if (clr) r_timer <= '0;
    else if (inc && !(&r_timer)) r_timer <= r_timer + 1'b1;
  assign tmo_hit = (cfg_timeout != '0) && (r_timer == cfg_timeout);
endmodule

// File: rtl/axis_burst_reader.sv
// axis_burst_reader: packs an AXI-stream word stream into tlast-framed bursts
//   clk/rstn        clock, async active-low reset
//   axis_rx         input stream from the FIFO (slave)
//   axis_tx         burst stream out (master), tlast on the final word of a burst
//   cfg_burst_len   words per burst (0 -> 1, above 2**BURST_BITS -> 2**BURST_BITS)
//   cfg_timeout     idle cycles before a partial burst closes; 0 disables
//   flush           pulse closing the current partial burst
//   stat_bursts/stat_partial  burst counters, present only with AXIS_BURST_STAT_EN
module axis_burst_reader import axis_burst_pkg::*; #(
  parameter int WIDTH        = 12,
  parameter int BURST_BITS   = 4,
  parameter int TIMEOUT_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  axis_burst_reader_if.slave        axis_rx,
  axis_burst_reader_if.master       axis_tx,
  input  logic [BURST_BITS:0]       cfg_burst_len,
  input  logic [TIMEOUT_BITS-1:0]   cfg_timeout,
  input  logic                      flush
`ifdef AXIS_BURST_STAT_EN
  ,
  output logic [31:0]               stat_bursts,
  output logic [31:0]               stat_partial
`endif
);
  localparam int LW = BURST_BITS + 1;
  logic r_hv, r_ov, r_olast;
  logic [WIDTH-1:0] r_hdata, r_odata;
  logic [BURST_BITS-1:0] r_pos;
  logic [LW-1:0] r_len;
  logic w_tmo_hit, w_at_end, w_close, w_move, w_accept;
  close_e w_reason;
  assign w_at_end = ({1'b0, r_pos} == r_len - 1'b1);
  assign w_reason = w_at_end ? CLOSE_LEN : (w_tmo_hit && !axis_rx.tvalid) ? CLOSE_TMO : flush ? CLOSE_FLUSH : CLOSE_NONE;
  assign w_close = (w_reason != CLOSE_NONE);
  // the held word only leaves once its successor arrives or the burst closes
  assign w_move = r_hv && (!r_ov || axis_tx.tready) && (w_close || axis_rx.tvalid);
  assign axis_rx.tready = !r_hv || w_move;
  assign w_accept = axis_rx.tvalid && axis_rx.tready;
  assign axis_tx.tdata = r_odata;
  assign axis_tx.tvalid = r_ov;
  assign axis_tx.tlast = r_olast;
  axis_burst_timer #(.TIMEOUT_BITS(TIMEOUT_BITS)) u_timer (
    .clk(clk),
    .rstn(rstn),
    .clr(w_accept || w_move),
    .inc(r_hv && !axis_rx.tvalid && !w_move),
    .cfg_timeout(cfg_timeout),
    .tmo_hit(w_tmo_hit)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_hv <= 1'b0;
      r_ov <= 1'b0;
      r_olast <= 1'b0;
      r_pos <= '0;
      r_len <= LW'(1);
      r_hdata <= '0;
      r_odata <= '0;
    end else begin
      if (w_accept) r_hdata <= axis_rx.tdata;
      // a word starts a new burst when nothing is held, or when the held word closes this cycle
      if (w_accept && (!r_hv || (w_move && w_close)))
        r_len <= LW'(clamp_len(32'(cfg_burst_len), 32'(2 ** BURST_BITS)));
      r_hv <= w_accept || (r_hv && !w_move);
      if (w_move) begin
        r_odata <= r_hdata;
        r_ov <= 1'b1;
        r_olast <= w_close;
        r_pos <= w_close ? '0 : r_pos + 1'b1;
      end else if (r_ov && axis_tx.tready) r_ov <= 1'b0;
    end
`ifdef AXIS_BURST_STAT_EN
  logic r_opartial;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_opartial <= 1'b0;
      stat_bursts <= '0;
      stat_partial <= '0;
    end else begin
      if (w_move) r_opartial <= (w_reason inside {CLOSE_TMO, CLOSE_FLUSH});
      if (r_ov && axis_tx.tready && r_olast) begin
        stat_bursts <= stat_bursts + 32'd1;
        if (r_opartial) stat_partial <= stat_partial + 32'd1;
      end
    end
`endif
endmodule
